// File: rtl/video_adaptive_binarizer.sv
// RGB-to-luminance binarizer with fixed, adaptive (previous-frame mean), inverted and gray modes.
// Fixed 3-cycle pixel pipeline; the frame mean comes from a serial divider started at each vsync rise.
module video_adaptive_binarizer #(
  parameter int DATA_W      = 8,
  parameter int PIX_CNT_W   = 22,
  parameter int INIT_THRESH = 2 ** (DATA_W - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_W-1:0]     cfg_threshold,
  input  logic                  pre_image_vsync,
  input  logic                  pre_image_clken,
  input  logic                  pre_data_valid,
  input  logic [3*DATA_W-1:0]   pre_image_data,
  output logic                  pos_image_vsync,
  output logic                  pos_image_clken,
  output logic                  pos_data_valid,
  output logic [3*DATA_W-1:0]   pos_image_data,
  output logic [DATA_W-1:0]     frame_mean,
  output logic                  mean_valid
);
  localparam int SUM_W  = DATA_W + PIX_CNT_W;
  localparam int PROD_W = DATA_W + 8;
  localparam int CNT_W  = $clog2(SUM_W);
  localparam logic [PIX_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} div_state_t;

  logic [2:0]           vsync_sr_r, clken_sr_r, valid_sr_r;
  logic [PROD_W-1:0]    r_prod_r, g_prod_r, b_prod_r, y_sum_s;
  logic [DATA_W-1:0]    y_r, thr_s;
  logic                 hit_s;
  logic [3*DATA_W-1:0]  out_data_s, out_data_r;
  logic                 vsync_prev_r, frame_armed_r, boundary_s, start_s;
  logic [1:0]           shadow_mode_r;
  logic [DATA_W-1:0]    shadow_thr_r;
  logic [SUM_W-1:0]     pix_sum_r, quo_r;
  logic [PIX_CNT_W-1:0] pix_cnt_r, rem_r, divisor_r, rem_s;
  logic [PIX_CNT_W:0]   trial_s;
  logic                 q_bit_s;
  logic [CNT_W-1:0]     bit_cnt_r;
  div_state_t           state_r, state_s;
  logic [DATA_W-1:0]    frame_mean_r, mean_sat_s;
  logic                 mean_valid_r;

  assign boundary_s = pre_image_vsync & ~vsync_prev_r;
  assign start_s    = boundary_s & frame_armed_r & (pix_cnt_r != '0);
  assign y_sum_s    = r_prod_r + g_prod_r + b_prod_r;

  // Stream control delay line, kept in lockstep with the three data stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_sr_r <= 3'b000;
      clken_sr_r <= 3'b000;
      valid_sr_r <= 3'b000;
    end else begin
      vsync_sr_r <= {vsync_sr_r[1:0], pre_image_vsync};
      clken_sr_r <= {clken_sr_r[1:0], pre_image_clken};
      valid_sr_r <= {valid_sr_r[1:0], pre_data_valid};
    end
  end

  // Stages 1 and 2: weighted products, then luminance; weights sum to 256
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod_r <= '0;
      g_prod_r <= '0;
      b_prod_r <= '0;
      y_r      <= '0;
    end else begin
      r_prod_r <= PROD_W'(pre_image_data[3*DATA_W-1 -: DATA_W]) * PROD_W'(77);
      g_prod_r <= PROD_W'(pre_image_data[2*DATA_W-1 -: DATA_W]) * PROD_W'(150);
      b_prod_r <= PROD_W'(pre_image_data[DATA_W-1:0]) * PROD_W'(29);
      y_r      <= DATA_W'(y_sum_s >> 8);
    end
  end

  // Stage 3 decision; adaptive mode reads the live frame mean
  always_comb begin
    thr_s      = shadow_thr_r;
    out_data_s = '0;
    if (shadow_mode_r == 2'd1) thr_s = frame_mean_r;
    else                       thr_s = shadow_thr_r;
    hit_s = (y_r >= thr_s);
    if (valid_sr_r[1]) begin
      case (shadow_mode_r)
        2'd0, 2'd1: out_data_s = {(3*DATA_W){hit_s}};
        2'd2:       out_data_s = {(3*DATA_W){~hit_s}};
        2'd3:       out_data_s = {y_r, y_r, y_r};
        default:    out_data_s = '0;
      endcase
    end else begin
      out_data_s = '0;
    end
  end

  // Stage 3 output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_data_r <= '0;
    else     out_data_r <= out_data_s;
  end

  // Frame boundary bookkeeping: config shadows and the luminance accumulator.
  // The pixel sitting in stage 2 on the boundary cycle opens the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_prev_r  <= 1'b0;
      frame_armed_r <= 1'b0;
      shadow_mode_r <= 2'd0;
      shadow_thr_r  <= DATA_W'(INIT_THRESH);
      pix_sum_r     <= '0;
      pix_cnt_r     <= '0;
    end else begin
      vsync_prev_r <= pre_image_vsync;
      if (boundary_s) begin
        frame_armed_r <= 1'b1;
        shadow_mode_r <= cfg_mode;
        shadow_thr_r  <= cfg_threshold;
        pix_sum_r     <= valid_sr_r[1] ? SUM_W'(y_r) : '0;
        pix_cnt_r     <= valid_sr_r[1] ? PIX_CNT_W'(1) : '0;
      end else if (valid_sr_r[1] && (pix_cnt_r != CNT_MAX)) begin
        pix_sum_r <= pix_sum_r + SUM_W'(y_r);
        pix_cnt_r <= pix_cnt_r + PIX_CNT_W'(1);
      end
    end
  end

  // Divider state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Divider next state: a new boundary always restarts (or cancels) the division
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_s = DIV;
        else         state_s = IDLE;
      end
      DIV: begin
        if (boundary_s)                           state_s = start_s ? DIV : IDLE;
        else if (bit_cnt_r == CNT_W'(SUM_W - 1)) state_s = DONE;
        else                                      state_s = DIV;
      end
      DONE:    state_s = start_s ? DIV : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // One restoring shift-subtract step and quotient saturation
  always_comb begin
    trial_s = {rem_r, quo_r[SUM_W-1]};
    q_bit_s = (trial_s >= {1'b0, divisor_r});
    if (q_bit_s) rem_s = PIX_CNT_W'(trial_s - {1'b0, divisor_r});
    else         rem_s = trial_s[PIX_CNT_W-1:0];
    if (|quo_r[SUM_W-1:DATA_W]) mean_sat_s = '1;
    else                        mean_sat_s = quo_r[DATA_W-1:0];
  end

  // Divider datapath and frame-mean publication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_r        <= '0;
      rem_r        <= '0;
      divisor_r    <= '0;
      bit_cnt_r    <= '0;
      frame_mean_r <= DATA_W'(INIT_THRESH);
      mean_valid_r <= 1'b0;
    end else begin
      mean_valid_r <= 1'b0;
      if (start_s) begin
        quo_r     <= pix_sum_r;
        divisor_r <= pix_cnt_r;
        rem_r     <= '0;
        bit_cnt_r <= '0;
      end else if (state_r == DIV) begin
        quo_r     <= {quo_r[SUM_W-2:0], q_bit_s};
        rem_r     <= rem_s;
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end
      if (state_r == DONE) begin
        frame_mean_r <= mean_sat_s;
        mean_valid_r <= 1'b1;
      end
    end
  end

  assign pos_image_vsync = vsync_sr_r[2];
  assign pos_image_clken = clken_sr_r[2];
  assign pos_data_valid  = valid_sr_r[2];
  assign pos_image_data  = out_data_r;
  assign frame_mean      = frame_mean_r;
  assign mean_valid      = mean_valid_r;
endmodule

// File: tb/tb_video_adaptive_binarizer.sv
// Directed bench for video_adaptive_binarizer: per-cycle output scoreboard plus frame-mean checks.
`timescale 1ns/1ps
module tb_video_adaptive_binarizer;
  localparam int SUM_W    = 30;
  localparam int LAT_MEAN = SUM_W + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_threshold;
  logic        pre_image_vsync, pre_image_clken, pre_data_valid;
  logic [23:0] pre_image_data;
  logic        pos_image_vsync, pos_image_clken, pos_data_valid;
  logic [23:0] pos_image_data;
  logic [7:0]  frame_mean;
  logic        mean_valid;

  video_adaptive_binarizer dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_threshold(cfg_threshold),
    .pre_image_vsync(pre_image_vsync), .pre_image_clken(pre_image_clken),
    .pre_data_valid(pre_data_valid), .pre_image_data(pre_image_data),
    .pos_image_vsync(pos_image_vsync), .pos_image_clken(pos_image_clken),
    .pos_data_valid(pos_data_valid), .pos_image_data(pos_image_data),
    .frame_mean(frame_mean), .mean_valid(mean_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [26:0] exp; } item_t;
  item_t sb[$];
  int total = 0, bad = 0, cyc = 0, pulses = 0;
  logic [1:0] m_mode;
  logic [7:0] m_thr, m_mean;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mean_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] gray(input logic [7:0] v);
    return {v, v, v};
  endfunction

  function automatic logic [23:0] model_out(input logic [23:0] rgb, input logic vl);
    int y;
    logic [7:0] t;
    logic hit;
    y   = (int'(rgb[23:16]) * 77 + int'(rgb[15:8]) * 150 + int'(rgb[7:0]) * 29) / 256;
    t   = (m_mode == 2'd1) ? m_mean : m_thr;
    hit = (y >= int'(t));
    if (!vl) return 24'h000000;
    case (m_mode)
      2'd0, 2'd1: return hit ? 24'hFFFFFF : 24'h000000;
      2'd2:       return hit ? 24'h000000 : 24'hFFFFFF;
      default:    return {3{y[7:0]}};
    endcase
  endfunction

  // Pipeline monitor: every driven cycle must reappear 3 clocks later
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      item_t it;
      it = sb.pop_front();
      chk("pipe", {pos_image_vsync, pos_image_clken, pos_data_valid, pos_image_data}, it.exp);
    end
  end

  task automatic step(input logic vs, input logic ck, input logic vl, input logic [23:0] rgb);
    @(posedge clk); #1;
    pre_image_vsync = vs; pre_image_clken = ck; pre_data_valid = vl; pre_image_data = rgb;
    sb.push_back('{due: cyc + 3, exp: {vs, ck, vl, model_out(rgb, vl)}});
  endtask

  task automatic pix(input logic [23:0] rgb, input int n);
    repeat (n) step(1'b0, 1'b1, 1'b1, rgb);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 24'h000000);
  endtask

  task automatic vs_edge(input logic vl, input logic [23:0] rgb);
    m_mode = cfg_mode;
    m_thr  = cfg_threshold;
    step(1'b1, vl, vl, rgb);
  endtask

  task automatic wait_pulse(input logic [7:0] exp_mean, input string tag);
    int lat = 0;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      step(1'b0, 1'b0, 1'b0, 24'h000000);
      @(negedge clk);
      if (mean_valid === 1'b1) lat = k;
    end
    chk({tag, "_lat"}, lat, LAT_MEAN);
    chk({tag, "_mean"}, frame_mean, exp_mean);
    step(1'b0, 1'b0, 1'b0, 24'h000000);
    @(negedge clk);
    chk({tag, "_len"}, mean_valid, 32'd0);
    m_mean = exp_mean;
  endtask

  task automatic no_pulse(input int n, input logic [7:0] exp_mean, input string tag);
    int p0 = pulses;
    repeat (n) step(1'b0, 1'b0, 1'b0, 24'h000000);
    @(negedge clk); #1;
    chk({tag, "_pulses"}, pulses - p0, 32'd0);
    chk({tag, "_mean"}, frame_mean, exp_mean);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst = 1'b1; cfg_mode = 2'd0; cfg_threshold = 8'd100;
    pre_image_vsync = 1'b1; pre_image_clken = 1'b1; pre_data_valid = 1'b1; pre_image_data = 24'hFFFFFF;
    m_mode = 2'd0; m_thr = 8'd128; m_mean = 8'd128;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {pos_image_vsync, pos_image_clken, pos_data_valid, pos_image_data}, 32'd0);
    chk("rst_mean", frame_mean, 32'd128);
    chk("rst_mv", mean_valid, 32'd0);
    pre_image_vsync = 1'b0; pre_image_clken = 1'b0; pre_data_valid = 1'b0; pre_image_data = 24'h0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Fixed threshold 100
    vs_edge(1'b0, 24'h0); idle(3);
    pix(gray(8'd100), 1); pix(gray(8'd99), 1); pix(24'hFF0000, 1); idle(3);

    // Adaptive: first mean is (100+99+76)/3, then a 60/200 frame gives 130
    cfg_mode = 2'd1; vs_edge(1'b0, 24'h0); wait_pulse(8'd91, "mean_init");
    pix(gray(8'd60), 1000); pix(gray(8'd200), 1000); idle(3);
    vs_edge(1'b0, 24'h0); wait_pulse(8'd130, "mean_frame");
    pix(gray(8'd129), 1); pix(gray(8'd130), 1); idle(3);

    // Inverted and gray passthrough at threshold 50
    cfg_mode = 2'd2; cfg_threshold = 8'd50; vs_edge(1'b0, 24'h0); wait_pulse(8'd129, "mean_m2");
    pix(gray(8'd50), 1); pix(gray(8'd49), 1); idle(3);
    cfg_mode = 2'd3; vs_edge(1'b0, 24'h0); wait_pulse(8'd49, "mean_m3");
    pix(gray(8'd50), 1); pix(24'hFF0000, 1); idle(3);

    // Mid-frame mode change waits for the next boundary
    cfg_mode = 2'd0; cfg_threshold = 8'd100; vs_edge(1'b0, 24'h0); wait_pulse(8'd63, "mean_m0");
    pix(gray(8'd150), 1); cfg_mode = 2'd2; pix(gray(8'd150), 2); idle(3);
    vs_edge(1'b0, 24'h0); wait_pulse(8'd150, "mean_chg");
    pix(gray(8'd150), 1); idle(3);
    vs_edge(1'b0, 24'h0); wait_pulse(8'd150, "mean_one");

    // Empty frame: no division
    idle(3);
    vs_edge(1'b0, 24'h0); no_pulse(SUM_W + 8, 8'd150, "empty");

    // Second boundary 5 clocks after the first: only the newest frame reports
    pix(gray(8'd200), 4); idle(3);
    p0 = pulses;
    vs_edge(1'b1, gray(8'd40)); pix(gray(8'd40), 2); idle(2);
    vs_edge(1'b0, 24'h0); wait_pulse(8'd40, "mean_dbl");
    idle(SUM_W);
    chk("dbl_pulses", pulses - p0, 32'd1);

    // Reset in the middle of a division
    pix(gray(8'd80), 3); idle(3);
    vs_edge(1'b0, 24'h0); pix(gray(8'd20), 5);
    @(posedge clk); #3;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_data", pos_image_data, 32'd0);
    chk("mid_rst_ctl", {pos_image_vsync, pos_image_clken, pos_data_valid}, 32'd0);
    chk("mid_rst_mean", frame_mean, 32'd128);
    chk("mid_rst_mv", mean_valid, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pre_image_vsync = 1'b0; pre_image_clken = 1'b0; pre_data_valid = 1'b0; pre_image_data = 24'h0;
    cfg_mode = 2'd0; m_mode = 2'd0; m_thr = 8'd128; m_mean = 8'd128;
    pix(gray(8'd110), 1); pix(gray(8'd130), 1); idle(3);
    vs_edge(1'b0, 24'h0); no_pulse(SUM_W + 8, 8'd128, "post_rst_first");
    pix(gray(8'd70), 3); idle(3);
    vs_edge(1'b0, 24'h0); wait_pulse(8'd70, "post_rst_second");
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
